jedro_1_rf_sequencer: RTL and testbench

Single-port register-file controller for jedro_1. It shares the one `addr/data/we` port of `jedro_1_regfile` between two requesters: the decode-stage operand reader (rs1 + rs2 pair) and the writeback stage (rd). It issues each read pair as an atomic two-access sequence, absorbing the regfile's 1-cycle registered read latency, and returns both operands on a valid/ready response channel.

---
 rtl/jedro_1_rf_sequencer_pkg.sv | 30 +++
 rtl/jedro_1_rf_sequencer_if.sv | 44 ++++
 rtl/jedro_1_rf_arb.sv | 46 ++++
 rtl/jedro_1_rf_sequencer.sv | 112 +++++++++++
 tb/tb_jedro_1_rf_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jedro_1_rf_sequencer_pkg.sv
// Shared encodings and default widths for the jedro_1 register-file sequencer.
// Pure declarations: no logic, no latency, no backpressure.
package jedro_1_pkg;

  localparam int DATA_WIDTH_DEF   = 32;
  localparam int ADDR_WIDTH_DEF   = 5;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RS1  = 3'd2;
  localparam logic [2:0] ST_RS2  = 3'd3;
  localparam logic [2:0] ST_RCAP = 3'd4;
  localparam logic [2:0] ST_RSP  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WR   = ST_WR,
    S_RS1  = ST_RS1,
    S_RS2  = ST_RS2,
    S_RCAP = ST_RCAP,
    S_RSP  = ST_RSP
  } seq_state_e;

  // Counter wide enough to hold STARVE_LIMIT, never zero-width.
  function automatic int starve_cnt_width(input int limit);
    return $clog2(limit + 2);
  endfunction

endpackage

// File: rtl/jedro_1_rf_sequencer_if.sv
// Bundle of the read-request, read-response, write-request and regfile-port signals.
// master = requesters/regfile side, slave = sequencer side.
interface jedro_1_rf_sequencer_if
  import jedro_1_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

  logic                  rreq_valid;
  logic                  rreq_ready;
  logic [ADDR_WIDTH-1:0] rs1_addr;
  logic [ADDR_WIDTH-1:0] rs2_addr;

  logic                  rrsp_valid;
  logic                  rrsp_ready;
  logic [DATA_WIDTH-1:0] rs1_data;
  logic [DATA_WIDTH-1:0] rs2_data;

  logic                  wreq_valid;
  logic                  wreq_ready;
  logic [ADDR_WIDTH-1:0] wreq_addr;
  logic [DATA_WIDTH-1:0] wreq_data;

  logic [ADDR_WIDTH-1:0] rf_addr;
  logic [DATA_WIDTH-1:0] rf_data;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_rdata;

  modport master (
    output rreq_valid, rs1_addr, rs2_addr, rrsp_ready,
    output wreq_valid, wreq_addr, wreq_data, rf_rdata,
    input  rreq_ready, rrsp_valid, rs1_data, rs2_data,
    input  wreq_ready, rf_addr, rf_data, rf_we
  );

  modport slave (
    input  rreq_valid, rs1_addr, rs2_addr, rrsp_ready,
    input  wreq_valid, wreq_addr, wreq_data, rf_rdata,
    output rreq_ready, rrsp_valid, rs1_data, rs2_data,
    output wreq_ready, rf_addr, rf_data, rf_we
  );

endinterface

// File: rtl/jedro_1_rf_arb.sv
// Read/write arbiter: write wins ties until a waiting read has lost STARVE_LIMIT times.
// Readies are combinational (0 cycles) and only ever high while the sequencer is idle.
module jedro_1_rf_arb
  import jedro_1_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic idle_i,
  input  logic rreq_valid_i,
  input  logic wreq_valid_i,
  output logic rreq_ready_o,
  output logic wreq_ready_o
);

  localparam int CW = starve_cnt_width(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_q;
  logic          starved;

  assign starved = (starve_cnt_q == CW'(STARVE_LIMIT));

  always_comb begin
    rreq_ready_o = 1'b0;
    wreq_ready_o = 1'b0;
    if (idle_i && !rst_i) begin
      rreq_ready_o = rreq_valid_i && (!wreq_valid_i || starved);
      wreq_ready_o = wreq_valid_i && !rreq_ready_o;
    end
  end

  // Only idle cycles are arbitration points; busy cycles leave the count alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else if (idle_i) begin
      if (rreq_ready_o || !rreq_valid_i) begin
        starve_cnt_q <= '0;
      end else if (wreq_ready_o && !starved) begin
        starve_cnt_q <= starve_cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/jedro_1_rf_sequencer.sv
// Shares the single regfile port between an rs1/rs2 operand reader and a writeback port.
// Write: 2-cycle occupancy. Read: response 4 cycles after accept, held until rrsp_ready.
module jedro_1_rf_sequencer
  import jedro_1_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input logic                   clk_i,
  input logic                   rst_i,
  jedro_1_rf_sequencer_if.slave rf_if
);

  seq_state_e            state_q;
  logic [ADDR_WIDTH-1:0] rs1_addr_q;
  logic [ADDR_WIDTH-1:0] rs2_addr_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [DATA_WIDTH-1:0] rs2_data_q;

  logic idle;
  logic rreq_ready;
  logic wreq_ready;
  logic rd_acc;
  logic wr_acc;

  assign idle = (state_q == S_IDLE);

  jedro_1_rf_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .idle_i      (idle),
    .rreq_valid_i(rf_if.rreq_valid),
    .wreq_valid_i(rf_if.wreq_valid),
    .rreq_ready_o(rreq_ready),
    .wreq_ready_o(wreq_ready)
  );

  assign rf_if.rreq_ready = rreq_ready;
  assign rf_if.wreq_ready = wreq_ready;
  assign rd_acc = rf_if.rreq_valid && rreq_ready;
  assign wr_acc = rf_if.wreq_valid && wreq_ready;

  // rf_rdata lags rf_addr by one cycle: rs1 lands during RS2, rs2 during RCAP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rd_acc) begin
            rs1_addr_q <= rf_if.rs1_addr;
            rs2_addr_q <= rf_if.rs2_addr;
            state_q    <= S_RS1;
          end else if (wr_acc) begin
            wr_addr_q <= rf_if.wreq_addr;
            wr_data_q <= rf_if.wreq_data;
            state_q   <= S_WR;
          end
        end
        S_WR:  state_q <= S_IDLE;
        S_RS1: state_q <= S_RS2;
        S_RS2: begin
          rs1_data_q <= rf_if.rf_rdata;
          state_q    <= S_RCAP;
        end
        S_RCAP: begin
          rs2_data_q <= rf_if.rf_rdata;
          state_q    <= S_RSP;
        end
        S_RSP: begin
          if (rf_if.rrsp_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rf_if.rrsp_valid = (state_q == S_RSP);
  assign rf_if.rs1_data   = rs1_data_q;
  assign rf_if.rs2_data   = rs2_data_q;

  // x0 writes still spend the WR cycle but never strobe the regfile.
  assign rf_if.rf_we = (state_q == S_WR) && !rst_i && (wr_addr_q != '0);

  always_comb begin
    rf_if.rf_addr = '0;
    rf_if.rf_data = '0;
    case (state_q)
      S_WR: begin
        rf_if.rf_addr = wr_addr_q;
        rf_if.rf_data = wr_data_q;
      end
      S_RS1:   rf_if.rf_addr = rs1_addr_q;
      S_RS2:   rf_if.rf_addr = rs2_addr_q;
      default: rf_if.rf_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_jedro_1_rf_sequencer.sv
// Bench for jedro_1_rf_sequencer: directed scenarios plus random traffic against a
// transaction-level model of regfile contents, occupancy timing and starvation.
module tb_jedro_1_rf_sequencer;
  import jedro_1_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jedro_1_rf_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();

  jedro_1_rf_sequencer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rf_if(sif)
  );

  // Regfile with registered read, cleared by the same reset as the sequencer.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      sif.rf_rdata <= '0;
    end else begin
      if (sif.rf_we) rf_mem[sif.rf_addr] <= sif.rf_data;
      sif.rf_rdata <= rf_mem[sif.rf_addr];
    end
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Reference model: architectural register contents plus timing rules.
  logic [DW-1:0] m_mem [32];
  bit            m_rsp_pend = 1'b0;
  int            m_rsp_at   = 0;
  logic [DW-1:0] m_exp1, m_exp2;
  int            m_idle_at  = 0;
  int            m_wr_at    = -1;
  logic [AW-1:0] m_wr_addr  = '0;
  logic [DW-1:0] m_wr_data  = '0;
  int            m_starve   = 0;
  bit            m_zero_chk = 1'b0;

  bit            s_rst, s_idle, s_rv, s_hs_r, s_hs_w, s_hs_rsp, s_rsp_vld;
  logic [AW-1:0] s_rs1, s_rs2, s_waddr;
  logic [DW-1:0] s_wdata;

  task automatic cycle();
    bit idle, er, ew, ersp, ewe;
    @(negedge clk);
    idle  = !m_rsp_pend && (cyc >= m_idle_at);
    s_rst = rst;
    s_idle = idle && !rst;
    s_rv  = sif.rreq_valid;
    if (rst) begin
      chk("rreq_rdy_rst", 32'(sif.rreq_ready), 32'(0));
      chk("wreq_rdy_rst", 32'(sif.wreq_ready), 32'(0));
      chk("rf_we_rst", 32'(sif.rf_we), 32'(0));
    end else begin
      er = sif.rreq_valid && idle && (!sif.wreq_valid || m_starve == SL);
      ew = sif.wreq_valid && idle && !er;
      chk("rreq_rdy", 32'(sif.rreq_ready), 32'(er));
      chk("wreq_rdy", 32'(sif.wreq_ready), 32'(ew));
      ersp = m_rsp_pend && (cyc >= m_rsp_at);
      chk("rrsp_vld", 32'(sif.rrsp_valid), 32'(ersp));
      if (ersp) begin
        chk("rs1_data", sif.rs1_data, m_exp1);
        chk("rs2_data", sif.rs2_data, m_exp2);
      end
      ewe = (cyc == m_wr_at) && (m_wr_addr != '0);
      chk("rf_we", 32'(sif.rf_we), 32'(ewe));
      if (cyc == m_wr_at) begin
        chk("rf_addr_wr", 32'(sif.rf_addr), 32'(m_wr_addr));
        chk("rf_data_wr", sif.rf_data, m_wr_data);
      end
      if (idle) begin
        chk("rf_addr_idle", 32'(sif.rf_addr), 32'(0));
        chk("rf_data_idle", sif.rf_data, 32'(0));
      end
      if (m_zero_chk) begin
        chk("rs1_data_rstval", sif.rs1_data, 32'(0));
        chk("rs2_data_rstval", sif.rs2_data, 32'(0));
      end
    end
    s_hs_r    = sif.rreq_valid && sif.rreq_ready;
    s_hs_w    = sif.wreq_valid && sif.wreq_ready;
    s_rsp_vld = sif.rrsp_valid;
    s_hs_rsp  = sif.rrsp_valid && sif.rrsp_ready;
    s_rs1 = sif.rs1_addr; s_rs2 = sif.rs2_addr;
    s_waddr = sif.wreq_addr; s_wdata = sif.wreq_data;
    @(posedge clk);
    if (s_rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      m_rsp_pend = 1'b0;
      m_idle_at  = cyc + 1;
      m_wr_at    = -1;
      m_starve   = 0;
      m_zero_chk = 1'b1;
    end else begin
      m_zero_chk = 1'b0;
      if (s_hs_w) begin
        m_idle_at = cyc + 2;
        m_wr_at   = cyc + 1;
        m_wr_addr = s_waddr;
        m_wr_data = s_wdata;
        if (s_waddr != '0) m_mem[s_waddr] = s_wdata;
      end
      if (s_hs_r) begin
        m_rsp_pend = 1'b1;
        m_rsp_at   = cyc + 4;
        m_exp1     = m_mem[s_rs1];
        m_exp2     = m_mem[s_rs2];
      end
      if (s_hs_rsp) begin
        m_rsp_pend = 1'b0;
        m_idle_at  = cyc + 1;
      end
      if (s_idle) begin
        if (s_hs_r || !s_rv) m_starve = 0;
        else if (s_hs_w && m_starve < SL) m_starve++;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got = 1'b0;
    sif.wreq_valid = 1'b1; sif.wreq_addr = a; sif.wreq_data = d;
    for (int i = 0; i < 64 && !got; i++) begin
      cycle();
      if (s_hs_w) got = 1'b1;
    end
    if (!got) chk("wr_acc_timeout", 32'(0), 32'(1));
    sif.wreq_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    bit got = 1'b0;
    int acc = 0;
    int lat = 0;
    sif.rreq_valid = 1'b1; sif.rs1_addr = a; sif.rs2_addr = b;
    for (int i = 0; i < 64 && !got; i++) begin
      cycle();
      if (s_hs_r) got = 1'b1;
    end
    if (!got) chk("rd_acc_timeout", 32'(0), 32'(1));
    acc = cyc - 1;
    sif.rreq_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      cycle();
      if (s_hs_rsp) begin got = 1'b1; lat = cyc - 1 - acc; end
    end
    if (!got) chk("rsp_timeout", 32'(0), 32'(1));
    else chk("rd_latency", 32'(lat), 32'(4));
  endtask

  bit grants [$];

  initial begin
    bit got;
    sif.rreq_valid = 1'b0; sif.rs1_addr = '0; sif.rs2_addr = '0;
    sif.wreq_valid = 1'b0; sif.wreq_addr = '0; sif.wreq_data = '0;
    sif.rrsp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;

    // Write then read back with x0 as second operand.
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5, 5'd0);

    // x0 writes never strobe the regfile.
    do_write(5'd0, 32'h1234);
    do_read(5'd0, 5'd0);

    // Reset landing on the WR cycle suppresses the write.
    sif.wreq_valid = 1'b1; sif.wreq_addr = 5'd7; sif.wreq_data = 32'h55;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin cycle(); if (s_hs_w) got = 1'b1; end
    if (!got) chk("wr7_acc_timeout", 32'(0), 32'(1));
    sif.wreq_valid = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    do_read(5'd7, 5'd7);

    // Reset during RS2 discards the in-flight read.
    do_write(5'd6, 32'hCAFE0006);
    sif.rreq_valid = 1'b1; sif.rs1_addr = 5'd6; sif.rs2_addr = 5'd6;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin cycle(); if (s_hs_r) got = 1'b1; end
    if (!got) chk("rd6_acc_timeout", 32'(0), 32'(1));
    sif.rreq_valid = 1'b0;
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    cycle();
    chk("rsp_after_rst", 32'(s_rsp_vld), 32'(0));
    do_read(5'd0, 5'd0);

    // Response stall: data held, writes locked out, write accepted right after.
    do_write(5'd3, 32'hA);
    do_write(5'd4, 32'hB);
    sif.rrsp_ready = 1'b0;
    sif.rreq_valid = 1'b1; sif.rs1_addr = 5'd3; sif.rs2_addr = 5'd4;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin cycle(); if (s_hs_r) got = 1'b1; end
    if (!got) chk("rd34_acc_timeout", 32'(0), 32'(1));
    sif.rreq_valid = 1'b0;
    sif.wreq_valid = 1'b1; sif.wreq_addr = 5'd9; sif.wreq_data = 32'h99;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin cycle(); if (s_rsp_vld) got = 1'b1; end
    if (!got) chk("rsp34_timeout", 32'(0), 32'(1));
    repeat (10) cycle();
    sif.rrsp_ready = 1'b1;
    cycle();
    chk("rsp34_hs", 32'(s_hs_rsp), 32'(1));
    cycle();
    chk("wr_after_rsp", 32'(s_hs_w), 32'(1));
    sif.wreq_valid = 1'b0;
    cycle();

    // Both requesters saturated: four writes then one read, repeating.
    sif.rreq_valid = 1'b1; sif.rs1_addr = 5'd9; sif.rs2_addr = 5'd3;
    sif.wreq_valid = 1'b1; sif.wreq_addr = 5'd10; sif.wreq_data = $urandom;
    for (int i = 0; i < 600 && grants.size() < 20; i++) begin
      cycle();
      if (s_hs_w) begin
        grants.push_back(1'b0);
        sif.wreq_addr = 5'($urandom_range(1, 15)); sif.wreq_data = $urandom;
      end
      if (s_hs_r) begin
        grants.push_back(1'b1);
        sif.rs1_addr = 5'($urandom_range(0, 15)); sif.rs2_addr = 5'($urandom_range(0, 15));
      end
    end
    sif.rreq_valid = 1'b0; sif.wreq_valid = 1'b0;
    chk("starve_grants", 32'(grants.size()), 32'(20));
    for (int i = 0; i < grants.size(); i++)
      chk($sformatf("starve_seq[%0d]", i), 32'(grants[i]), 32'((i % 5) == 4));
    repeat (10) cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if (!sif.rreq_valid || s_hs_r) begin
        sif.rreq_valid = ($urandom_range(0, 2) != 0);
        sif.rs1_addr = 5'($urandom_range(0, 7));
        sif.rs2_addr = 5'($urandom_range(0, 7));
      end
      if (!sif.wreq_valid || s_hs_w) begin
        sif.wreq_valid = ($urandom_range(0, 2) != 0);
        sif.wreq_addr = 5'($urandom_range(0, 7));
        sif.wreq_data = $urandom;
      end
      sif.rrsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    sif.rreq_valid = 1'b0; sif.wreq_valid = 1'b0; sif.rrsp_ready = 1'b1;
    repeat (12) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
